// File: rtl/framebuffer_writer.sv
`default_nettype none
// ============================================================================
// Module   : framebuffer_writer
// Brief    : Packs an 8-bit grayscale pixel stream into 16-bit words (even
//            pixel in the low byte) and writes them to consecutive word
//            addresses of a frame buffer, tracking the row/column position.
//            A start-of-frame beat always restarts the frame at BASE_ADDR.
// Revision : 1.0 - initial release
// ============================================================================
module framebuffer_writer #(
  parameter logic [13:0] BASE_ADDR     = 14'h0000,
  parameter int          WORDS_PER_ROW = 64,
  parameter int          ROWS          = 256
) (
  input  logic        o_clk,
  input  logic        rst,
  input  logic        pixel_valid,
  input  logic [7:0]  pixel_data,
  input  logic        pixel_sof,
  output logic        pixel_ready,
  input  logic        mem_busy,
  output logic        mem_we,
  output logic [13:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [7:0]  row,
  output logic [5:0]  col,
  output logic        frame_done,
  output logic        sof_err
);

  localparam logic [5:0] c_LAST_COL = 6'(WORDS_PER_ROW - 1);
  localparam logic [7:0] c_LAST_ROW = 8'(ROWS - 1);

  // IDLE waits for SOF, LOW expects the even pixel, HIGH the odd pixel,
  // WRITE holds the packed word on the memory port until it is taken.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOW   = 2'd1,
    S_HIGH  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_we;
  logic [13:0] r_addr;
  logic [15:0] r_wdata;
  logic [7:0]  r_row;
  logic [5:0]  r_col;
  logic        r_frame_done;
  logic        r_sof_err;

  logic        w_accept;
  logic        w_last_col;
  logic        w_last_word;

  // The stream is back-pressured only while a word is waiting on the memory.
  assign pixel_ready = (r_state != S_WRITE);
  assign w_accept    = pixel_valid & pixel_ready;
  assign w_last_col  = (r_col == c_LAST_COL);
  assign w_last_word = w_last_col && (r_row == c_LAST_ROW);

  assign mem_we      = r_we;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign row         = r_row;
  assign col         = r_col;
  assign frame_done  = r_frame_done;
  assign sof_err     = r_sof_err;

  // Frame-packing state machine with registered memory-port and status outputs.
  always_ff @(posedge o_clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_addr       <= BASE_ADDR;
      r_wdata      <= 16'h0000;
      r_row        <= 8'd0;
      r_col        <= 6'd0;
      r_frame_done <= 1'b0;
      r_sof_err    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_sof_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Non-SOF beats are dropped until a frame starts.
          if (w_accept && pixel_sof) begin
            r_wdata[7:0] <= pixel_data;
            r_row        <= 8'd0;
            r_col        <= 6'd0;
            r_addr       <= BASE_ADDR;
            r_state      <= S_HIGH;
          end
        end

        S_LOW, S_HIGH: begin
          if (w_accept) begin
            if (pixel_sof) begin
              // Restart: any half-built word is abandoned, upper byte is
              // simply left to be overwritten by the next odd pixel.
              r_sof_err    <= 1'b1;
              r_wdata[7:0] <= pixel_data;
              r_row        <= 8'd0;
              r_col        <= 6'd0;
              r_addr       <= BASE_ADDR;
              r_state      <= S_HIGH;
            end else if (r_state == S_LOW) begin
              r_wdata[7:0] <= pixel_data;
              r_state      <= S_HIGH;
            end else begin
              r_wdata[15:8] <= pixel_data;
              r_we          <= 1'b1;
              r_state       <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          // The word is consumed on the first edge without mem_busy.
          if (!mem_busy) begin
            r_we <= 1'b0;
            if (w_last_word) begin
              r_frame_done <= 1'b1;
              r_row        <= 8'd0;
              r_col        <= 6'd0;
              r_addr       <= BASE_ADDR;
              r_state      <= S_IDLE;
            end else begin
              // Address runs as its own counter; 14-bit wrap is intended.
              r_addr <= r_addr + 14'd1;
              if (w_last_col) begin
                r_col <= 6'd0;
                r_row <= r_row + 8'd1;
              end else begin
                r_col <= r_col + 6'd1;
              end
              r_state <= S_LOW;
            end
          end
        end

        default: begin
          r_we    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
